regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: port A (ALU result) and port B (load data).
- Accepts at most one write per cycle through valid/ready handshakes, using round-robin on conflict.
- Queues accepted writes in arrival order in a DEPTH-entry FIFO and drains one entry per cycle into registered rw/writereg/datawritten-style outputs.
- Provides a pending-write query so read-side logic can detect a register that is still queued.

---
 rtl/regfile_wb_arbiter_if.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus bundle for regfile_wb_arbiter.
// The master side belongs to the requesters and read-side logic. It drives the port A/B
// requests (valid/addr/data) and the pending query address (chk_addr).
// The slave side belongs to the arbiter. It drives the readies, the registered
// register-file write port (wr_en/wr_addr/wr_data), the query result (chk_pending) and
// the FIFO occupancy (count/empty).
interface regfile_wb_arbiter_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) ();
    logic                     a_valid;
    logic                     a_ready;
    logic [ADDR_W-1:0]        a_addr;
    logic [DATA_W-1:0]        a_data;

    logic                     b_valid;
    logic                     b_ready;
    logic [ADDR_W-1:0]        b_addr;
    logic [DATA_W-1:0]        b_data;

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;

    logic [ADDR_W-1:0]        chk_addr;
    logic                     chk_pending;

    logic [$clog2(DEPTH):0]   count;
    logic                     empty;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, chk_addr,
        input  a_ready, b_ready, wr_en, wr_addr, wr_data, chk_pending, count, empty
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, chk_addr,
        output a_ready, b_ready, wr_en, wr_addr, wr_data, chk_pending, count, empty
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// It shares one register-file write port between port A (ALU result) and port B
// (load data). At most one request is accepted per cycle, and round-robin decides
// a conflict. Accepted writes are queued in a DEPTH-entry FIFO. The FIFO drains one
// entry per cycle into registered wr_en/wr_addr/wr_data.
// chk_addr/chk_pending reports whether a register still has a write queued or in flight.
// Ports: clk, rst_n (synchronous, active low). All other signals are on bus
// (regfile_wb_arbiter_if.slave).
// Optional feature: define REGFILE_ZERO_PROTECT_EN to drop writes to register 0.
// Such writes still complete their handshake.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant_b;   // 1: port B won the most recent transfer
    logic              out_en;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    logic              full;
    logic              a_grant;
    logic              b_grant;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic              pending;

    assign full = (cnt == CNT_W'(DEPTH));
    assign pop  = (cnt != '0);

    // Full blocks acceptance even when a pop happens in the same cycle.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (rst_n && !full) begin
            if (bus.a_valid && bus.b_valid) begin
                a_grant = last_grant_b;
                b_grant = !last_grant_b;
            end else begin
                a_grant = bus.a_valid;
                b_grant = bus.b_valid;
            end
        end
    end

    assign push_addr = b_grant ? bus.b_addr : bus.a_addr;
    assign push_data = b_grant ? bus.b_data : bus.a_data;

`ifdef REGFILE_ZERO_PROTECT_EN
    // The handshake completes, but a write to r0 is never stored.
    assign push = (a_grant || b_grant) && (push_addr != '0);
`else
    assign push = a_grant || b_grant;
`endif

    // Storage has no reset; the occupancy count defines which slots are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            last_grant_b <= 1'b1;
            out_en       <= 1'b0;
            out_addr     <= '0;
            out_data     <= '0;
        end else begin
            if (a_grant || b_grant) begin
                last_grant_b <= b_grant;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                out_en   <= 1'b1;
                out_addr <= fifo_addr[rd_ptr];
                out_data <= fifo_data[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_W'(1);
            end else begin
                out_en <= 1'b0;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        pending = out_en && (out_addr == bus.chk_addr);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < cnt) &&
                (fifo_addr[i] == bus.chk_addr)) begin
                pending = 1'b1;
            end
        end
`ifdef REGFILE_ZERO_PROTECT_EN
        if (bus.chk_addr == '0) begin
            pending = 1'b0;
        end
`endif
    end

    assign bus.a_ready     = a_grant;
    assign bus.b_ready     = b_grant;
    assign bus.wr_en       = out_en;
    assign bus.wr_addr     = out_addr;
    assign bus.wr_data     = out_data;
    assign bus.chk_pending = pending;
    assign bus.count       = cnt;
    assign bus.empty       = (cnt == '0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Two source queues act as the A/B requesters. A request stays presented until it
// is accepted. A queue-based reference model tracks the pending writes, the
// registered write port and the round-robin state.
// Build with +define+REGFILE_ZERO_PROTECT_EN to check the r0-drop variant.
module tb_regfile_wb_arbiter;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    ent_t        a_src[$];
    ent_t        b_src[$];
    ent_t        mq[$];          // writes accepted but not yet driven out
    bit          a_hold = 1'b0;
    bit          b_hold = 1'b0;
    int unsigned a_rate = 100;
    int unsigned b_rate = 100;
    bit          rand_chk = 1'b0;
    logic [ADDR_W-1:0] chk_sel = '0;
    logic              m_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    bit                lg_b;     // B was the last port to transfer
    bit                exp_ar;
    bit                exp_br;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
        lg_b   = 1'b1;
    endtask

    task automatic model_store(input ent_t e);
`ifdef REGFILE_ZERO_PROTECT_EN
        if (e.addr != '0) mq.push_back(e);
`else
        mq.push_back(e);
`endif
    endtask

    // One clock: present inputs, check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        ent_t e;
        bit   pend;
        if (!a_hold) a_hold = (a_src.size() > 0) && ($urandom_range(99) < a_rate);
        if (!b_hold) b_hold = (b_src.size() > 0) && ($urandom_range(99) < b_rate);
        bus.a_valid = a_hold;
        bus.b_valid = b_hold;
        if (a_hold) begin
            bus.a_addr = a_src[0].addr;
            bus.a_data = a_src[0].data;
        end else begin
            bus.a_addr = ADDR_W'($urandom);
            bus.a_data = $urandom;
        end
        if (b_hold) begin
            bus.b_addr = b_src[0].addr;
            bus.b_data = b_src[0].data;
        end else begin
            bus.b_addr = ADDR_W'($urandom);
            bus.b_data = $urandom;
        end
        if (rand_chk) chk_sel = ADDR_W'($urandom_range(7));
        bus.chk_addr = chk_sel;

        @(negedge clk);
        // Winner on a tie is whichever port did not transfer last.
        exp_ar = 1'b0;
        exp_br = 1'b0;
        if (rst_n && mq.size() < DEPTH) begin
            if (a_hold && (!b_hold || lg_b)) exp_ar = 1'b1;
            else if (b_hold)                 exp_br = 1'b1;
        end
        pend = m_en && (m_addr == chk_sel);
        foreach (mq[i]) if (mq[i].addr == chk_sel) pend = 1'b1;
`ifdef REGFILE_ZERO_PROTECT_EN
        if (chk_sel == '0) pend = 1'b0;
`endif
        check("a_ready",     64'(bus.a_ready),     64'(exp_ar));
        check("b_ready",     64'(bus.b_ready),     64'(exp_br));
        check("wr_en",       64'(bus.wr_en),       64'(m_en));
        check("wr_addr",     64'(bus.wr_addr),     64'(m_addr));
        check("wr_data",     64'(bus.wr_data),     64'(m_data));
        check("count",       64'(bus.count),       64'(mq.size()));
        check("empty",       64'(bus.empty),       64'(mq.size() == 0));
        check("chk_pending", 64'(bus.chk_pending), 64'(pend));
        check("count_le_depth", 64'(bus.count <= DEPTH), 64'(1));

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (mq.size() > 0) begin
                e      = mq.pop_front();
                m_en   = 1'b1;
                m_addr = e.addr;
                m_data = e.data;
            end else begin
                m_en = 1'b0;
            end
            if (exp_ar) begin
                e      = a_src.pop_front();
                a_hold = 1'b0;
                lg_b   = 1'b0;
                model_store(e);
            end
            if (exp_br) begin
                e      = b_src.pop_front();
                b_hold = 1'b0;
                lg_b   = 1'b1;
                model_store(e);
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            if (a_src.size() == 0 && b_src.size() == 0 && mq.size() == 0 && !m_en) done = 1'b1;
            else cycle();
        end
        check("drain_timeout", 64'(done), 64'(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.a_valid  = 1'b0;
        bus.a_addr   = '0;
        bus.a_data   = '0;
        bus.b_valid  = 1'b0;
        bus.b_addr   = '0;
        bus.b_data   = '0;
        bus.chk_addr = '0;
        model_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single A write, expected on wr_en two edges after acceptance.
        chk_sel = 5'd3;
        a_src.push_back('{addr: 5'd3, data: 32'h55});
        drain();

        // Continuous ties from reset: A wins first, then strict alternation.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            a_src.push_back('{addr: ADDR_W'(i),      data: 32'hA0 + i});
            b_src.push_back('{addr: ADDR_W'(10 + i), data: 32'hB0 + i});
        end
        drain();

        // Back-to-back burst on both ports.
        for (int i = 0; i < 8; i++) begin
            a_src.push_back('{addr: ADDR_W'(16 + i), data: $urandom});
            b_src.push_back('{addr: ADDR_W'(24 + i), data: $urandom});
        end
        drain();

        // Same register from both ports on consecutive cycles.
        chk_sel = 5'd7;
        a_src.push_back('{addr: 5'd7, data: 32'h1});
        cycle();
        b_src.push_back('{addr: 5'd7, data: 32'h2});
        drain();

        // Reset while writes are queued and in flight.
        for (int i = 0; i < 6; i++) begin
            a_src.push_back('{addr: ADDR_W'(i + 1), data: $urandom});
            b_src.push_back('{addr: ADDR_W'(i + 8), data: $urandom});
        end
        run(3);
        rst_n = 1'b0;
        cycle();
        a_src.delete();
        b_src.delete();
        a_hold = 1'b0;
        b_hold = 1'b0;
        cycle();
        rst_n = 1'b1;
        run(4);

        // Register 0 followed by a normal write.
        chk_sel = 5'd0;
        a_src.push_back('{addr: 5'd0, data: 32'hDEAD});
        a_src.push_back('{addr: 5'd5, data: 32'hBEEF});
        drain();

        // Randomised traffic with occasional resets.
        rand_chk = 1'b1;
        for (int i = 0; i < 400; i++) begin
            a_rate = $urandom_range(30, 100);
            b_rate = $urandom_range(30, 100);
            if (a_src.size() < 4 && $urandom_range(1) == 1)
                a_src.push_back('{addr: ADDR_W'($urandom_range(7)), data: $urandom});
            if (b_src.size() < 4 && $urandom_range(1) == 1)
                b_src.push_back('{addr: ADDR_W'($urandom_range(7)), data: $urandom});
            rst_n = ($urandom_range(79) != 0);
            cycle();
        end
        rst_n = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
